// File: rtl/alu_issue_stage_if.sv
// Handshake and datapath bundle between decode, the ALU issue stage, the ALU and the memory stage.
// The stage uses the slave view and its surroundings use the master view.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_operator;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_rs_value;
  logic [31:0] in_rt_value;
  logic [31:0] in_immediate;
  logic        in_use_immediate;
  logic        flush;
  logic        wb_write_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_value;
  logic [31:0] alu_operand1;
  logic [31:0] alu_operand2;
  logic [2:0]  alu_operator;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;

  modport slave (
    input  in_valid, in_operator, in_rs, in_rt, in_rd, in_rs_value, in_rt_value,
    input  in_immediate, in_use_immediate, flush,
    input  wb_write_enable, wb_rd, wb_value,
    input  alu_result, out_ready,
    output in_ready, alu_operand1, alu_operand2, alu_operator,
    output out_valid, out_result, out_rd
  );

  modport master (
    output in_valid, in_operator, in_rs, in_rt, in_rd, in_rs_value, in_rt_value,
    output in_immediate, in_use_immediate, flush,
    output wb_write_enable, wb_rd, wb_value,
    output alu_result, out_ready,
    input  in_ready, alu_operand1, alu_operand2, alu_operator,
    input  out_valid, out_result, out_rd
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-entry integer execute stage: issue register A (ID/EX) feeding the ALU, result register B (EX/MEM)
// feeding the memory stage, with writeback and B->A operand bypassing.
module alu_issue_stage (
  input logic          clock,
  input logic          reset,
  alu_issue_stage_if.slave bus
);
  typedef logic [31:0] int_t;

  logic       valid_a;
  logic [2:0] operator_a;
  logic [4:0] rs_a;
  logic [4:0] rt_a;
  logic [4:0] rd_a;
  int_t       rs_value_a;
  int_t       rt_value_a;
  int_t       immediate_a;
  logic       use_immediate_a;

  logic       valid_b;
  int_t       result_b;
  logic [4:0] rd_b;

  logic advance_a;
  logic advance_b;
  logic accept;
  int_t src1;
  int_t src2;

  // Register 0 is hardwired to zero, so it never matches a forwarding source.
  function automatic logic wb_match(input logic [4:0] idx, input logic we, input logic [4:0] wrd);
    return we && (wrd == idx) && (idx != 5'd0);
  endfunction

  assign advance_b    = !valid_b || bus.out_ready;
  assign advance_a    = valid_a && advance_b;
  assign bus.in_ready = (!valid_a || advance_a) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // B holds the youngest older result, so it outranks the writeback port.
  always_comb begin
    src1 = rs_value_a;
    if (valid_b && (rd_b == rs_a) && (rs_a != 5'd0)) begin
      src1 = result_b;
    end else if (wb_match(rs_a, bus.wb_write_enable, bus.wb_rd)) begin
      src1 = bus.wb_value;
    end
    src2 = rt_value_a;
    if (valid_b && (rd_b == rt_a) && (rt_a != 5'd0)) begin
      src2 = result_b;
    end else if (wb_match(rt_a, bus.wb_write_enable, bus.wb_rd)) begin
      src2 = bus.wb_value;
    end
  end

  assign bus.alu_operand1 = src1;
  assign bus.alu_operand2 = use_immediate_a ? immediate_a : src2;
  assign bus.alu_operator = operator_a;

  // A stalled entry keeps absorbing writebacks so it never leaves with a stale operand.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_a         <= 1'b0;
      operator_a      <= 3'd0;
      rs_a            <= 5'd0;
      rt_a            <= 5'd0;
      rd_a            <= 5'd0;
      rs_value_a      <= '0;
      rt_value_a      <= '0;
      immediate_a     <= '0;
      use_immediate_a <= 1'b0;
    end else if (accept) begin
      valid_a         <= 1'b1;
      operator_a      <= bus.in_operator;
      rs_a            <= bus.in_rs;
      rt_a            <= bus.in_rt;
      rd_a            <= bus.in_rd;
      rs_value_a      <= wb_match(bus.in_rs, bus.wb_write_enable, bus.wb_rd) ? bus.wb_value : bus.in_rs_value;
      rt_value_a      <= wb_match(bus.in_rt, bus.wb_write_enable, bus.wb_rd) ? bus.wb_value : bus.in_rt_value;
      immediate_a     <= bus.in_immediate;
      use_immediate_a <= bus.in_use_immediate;
    end else if (bus.flush || advance_a) begin
      valid_a <= 1'b0;
    end else if (valid_a) begin
      if (wb_match(rs_a, bus.wb_write_enable, bus.wb_rd)) begin
        rs_value_a <= bus.wb_value;
      end
      if (wb_match(rt_a, bus.wb_write_enable, bus.wb_rd)) begin
        rt_value_a <= bus.wb_value;
      end
    end
  end

  // A flushed entry that would have advanced is dropped instead of landing in B.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_b  <= 1'b0;
      result_b <= '0;
      rd_b     <= 5'd0;
    end else if (advance_a && !bus.flush) begin
      valid_b  <= 1'b1;
      result_b <= bus.alu_result;
      rd_b     <= rd_a;
    end else if (advance_b) begin
      valid_b <= 1'b0;
    end
  end

  assign bus.out_valid  = valid_b;
  assign bus.out_result = result_b;
  assign bus.out_rd     = rd_b;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized instruction stream
// checked against an architectural register-file model.
module tb_alu_issue_stage;
  logic clock;
  logic reset;
  int   test_count;
  int   fail_count;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
  } instr_t;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a | b;
      default: return 32'd0;
    endcase
  endfunction

  // External ALU seen by the stage.
  assign bus.alu_result = ref_alu(bus.alu_operator, bus.alu_operand1, bus.alu_operand2);

  task automatic set_idle();
    bus.in_valid = 1'b0;
    bus.in_operator = 3'd0;
    bus.in_rs = 5'd0;
    bus.in_rt = 5'd0;
    bus.in_rd = 5'd0;
    bus.in_rs_value = 32'd0;
    bus.in_rt_value = 32'd0;
    bus.in_immediate = 32'd0;
    bus.in_use_immediate = 1'b0;
    bus.flush = 1'b0;
    bus.wb_write_enable = 1'b0;
    bus.wb_rd = 5'd0;
    bus.wb_value = 32'd0;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                               input logic [31:0] imm, input logic use_imm);
    bus.in_valid = 1'b1;
    bus.in_operator = op;
    bus.in_rs = rs;
    bus.in_rt = rt;
    bus.in_rd = rd;
    bus.in_rs_value = rsv;
    bus.in_rt_value = rtv;
    bus.in_immediate = imm;
    bus.in_use_immediate = use_imm;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    bus.out_ready = 1'b1;
    reset = 1'b1;
    #1;
    test_count++; if (bus.out_valid !== 1'b0) begin $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); fail_count++; end
    test_count++; if (bus.out_result !== 32'd0) begin $display("[TB] FAIL reset_out_result: got %h want 0", bus.out_result); fail_count++; end
    test_count++; if (bus.out_rd !== 5'd0) begin $display("[TB] FAIL reset_out_rd: got %0d want 0", bus.out_rd); fail_count++; end
    test_count++; if (bus.in_ready !== 1'b1) begin $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); fail_count++; end
    test_count++; if ({bus.alu_operand1, bus.alu_operand2, bus.alu_operator} !== 67'd0) begin
      $display("[TB] FAIL reset_alu_outputs: got %h/%h/%0d want 0/0/0", bus.alu_operand1, bus.alu_operand2, bus.alu_operator); fail_count++; end
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(3'd0, 5'd1, 5'd2, 5'd5, 32'd3, 32'd4, 32'd0, 1'b0);
    step();
    applyStimulus(3'd0, 5'd1, 5'd2, 5'd6, 32'd10, 32'd20, 32'd0, 1'b0);
    step();
    test_count++; if ({bus.out_valid, bus.out_result} !== {1'b1, 32'd7}) begin
      $display("[TB] FAIL reset_prefill: got valid=%b result=%0d want valid=1 result=7", bus.out_valid, bus.out_result); fail_count++; end
    #2;
    reset = 1'b1;
    #1;
    test_count++; if ({bus.out_valid, bus.out_result} !== 33'd0) begin
      $display("[TB] FAIL reset_async_out: got valid=%b result=%0d want 0/0", bus.out_valid, bus.out_result); fail_count++; end
    test_count++; if (bus.in_ready !== 1'b1) begin $display("[TB] FAIL reset_async_in_ready: got %b want 1", bus.in_ready); fail_count++; end
    set_idle();
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      test_count++; if (bus.out_valid !== 1'b0) begin $display("[TB] FAIL reset_no_stale: cycle %0d got out_valid=%b want 0", i, bus.out_valid); fail_count++; end
    end
  endtask

  task automatic test_dependency();
    set_idle();
    bus.out_ready = 1'b1;
    applyStimulus(3'd0, 5'd2, 5'd3, 5'd1, 32'd5, 32'd7, 32'd0, 1'b0);
    step();
    applyStimulus(3'd1, 5'd1, 5'd3, 5'd4, 32'd0, 32'd7, 32'd0, 1'b0);
    #1;
    test_count++; if (bus.in_ready !== 1'b1) begin $display("[TB] FAIL dep_no_stall: got in_ready=%b want 1", bus.in_ready); fail_count++; end
    step();
    set_idle();
    #1;
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd1, 32'd12}) begin
      $display("[TB] FAIL dep_first: got valid=%b rd=%0d result=%0d want 1/1/12", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    test_count++; if (bus.alu_operand1 !== 32'd12) begin $display("[TB] FAIL dep_bypass_b: got operand1=%0d want 12", bus.alu_operand1); fail_count++; end
    step();
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd4, 32'd5}) begin
      $display("[TB] FAIL dep_second: got valid=%b rd=%0d result=%0d want 1/4/5", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    step();
    test_count++; if (bus.out_valid !== 1'b0) begin $display("[TB] FAIL dep_drain: got out_valid=%b want 0", bus.out_valid); fail_count++; end
  endtask

  task automatic test_immediate();
    set_idle();
    bus.out_ready = 1'b1;
    applyStimulus(3'd2, 5'd5, 5'd6, 5'd9, 32'h0000_00F0, 32'h0000_1234, 32'h0000_0F0F, 1'b1);
    step();
    set_idle();
    step();
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd9, 32'h0000_0FFF}) begin
      $display("[TB] FAIL imm_or: got valid=%b rd=%0d result=%h want 1/9/00000fff", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    step();
  endtask

  task automatic test_backpressure();
    set_idle();
    bus.out_ready = 1'b0;
    applyStimulus(3'd0, 5'd2, 5'd3, 5'd7, 32'd1, 32'd2, 32'd0, 1'b0);
    step();
    applyStimulus(3'd0, 5'd6, 5'd0, 5'd8, 32'd50, 32'd0, 32'd5, 1'b1);
    step();
    set_idle();
    for (int c = 1; c <= 3; c++) begin
      bus.wb_write_enable = (c == 2);
      bus.wb_rd = (c == 2) ? 5'd6 : 5'd0;
      bus.wb_value = (c == 2) ? 32'd100 : 32'd0;
      #1;
      test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd7, 32'd3}) begin
        $display("[TB] FAIL bp_stable: cycle %0d got valid=%b rd=%0d result=%0d want 1/7/3", c, bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
      test_count++; if (bus.in_ready !== 1'b0) begin $display("[TB] FAIL bp_in_ready: cycle %0d got %b want 0", c, bus.in_ready); fail_count++; end
      step();
    end
    bus.wb_write_enable = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    test_count++; if (bus.alu_operand1 !== 32'd100) begin $display("[TB] FAIL bp_wb_update: got operand1=%0d want 100", bus.alu_operand1); fail_count++; end
    step();
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd8, 32'd105}) begin
      $display("[TB] FAIL bp_release: got valid=%b rd=%0d result=%0d want 1/8/105", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    step();
    test_count++; if (bus.out_valid !== 1'b0) begin $display("[TB] FAIL bp_drain: got out_valid=%b want 0", bus.out_valid); fail_count++; end
  endtask

  task automatic test_r0();
    set_idle();
    bus.out_ready = 1'b1;
    applyStimulus(3'd0, 5'd2, 5'd0, 5'd0, 32'd4, 32'd0, 32'd5, 1'b1);
    step();
    applyStimulus(3'd0, 5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'd1, 1'b1);
    step();
    set_idle();
    #1;
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd0, 32'd9}) begin
      $display("[TB] FAIL r0_first: got valid=%b rd=%0d result=%0d want 1/0/9", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    step();
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd3, 32'd1}) begin
      $display("[TB] FAIL r0_no_forward: got valid=%b rd=%0d result=%0d want 1/3/1", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    step();
  endtask

  task automatic test_flush();
    set_idle();
    bus.out_ready = 1'b1;
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd10, 32'd1, 32'd0, 32'd1, 1'b1);
    step();
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd11, 32'd29, 32'd0, 32'd1, 1'b1);
    step();
    applyStimulus(3'd0, 5'd1, 5'd0, 5'd12, 32'd40, 32'd0, 32'd2, 1'b1);
    bus.flush = 1'b1;
    #1;
    test_count++; if (bus.in_ready !== 1'b0) begin $display("[TB] FAIL flush_in_ready: got %b want 0", bus.in_ready); fail_count++; end
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd10, 32'd2}) begin
      $display("[TB] FAIL flush_b_kept: got valid=%b rd=%0d result=%0d want 1/10/2", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    step();
    bus.flush = 1'b0;
    #1;
    test_count++; if (bus.out_valid !== 1'b0) begin
      $display("[TB] FAIL flush_killed: got valid=%b rd=%0d want valid=0", bus.out_valid, bus.out_rd); fail_count++; end
    step();
    set_idle();
    step();
    test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd12, 32'd42}) begin
      $display("[TB] FAIL flush_next: got valid=%b rd=%0d result=%0d want 1/12/42", bus.out_valid, bus.out_rd, bus.out_result); fail_count++; end
    step();
  endtask

  // Decode reads a committed register file; results written back one cycle after leaving the stage.
  // Expected results come from an in-order architectural register file.
  task automatic test_random();
    instr_t      pend;
    instr_t      inflight[$];
    instr_t      done_instr;
    logic [31:0] rf[32];
    logic [31:0] arch[32];
    logic [31:0] exp_val;
    logic [31:0] opb;
    bit          have_pend;
    bit          finished;
    logic        xfer_prev;
    logic [4:0]  xfer_rd;
    logic [31:0] xfer_val;
    logic        hold_prev;
    logic [4:0]  hold_rd;
    logic [31:0] hold_res;
    int          issued;
    int          rop;
    have_pend = 0;
    finished = 0;
    issued = 0;
    xfer_prev = 1'b0;
    xfer_rd = 5'd0;
    xfer_val = 32'd0;
    hold_prev = 1'b0;
    hold_rd = 5'd0;
    hold_res = 32'd0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = 32'd0;
      arch[i] = 32'd0;
    end
    set_idle();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (issued >= 300 && !have_pend && inflight.size() == 0) begin
        finished = 1;
        break;
      end
      if (bus.wb_write_enable && bus.wb_rd != 5'd0) rf[bus.wb_rd] = bus.wb_value;
      bus.wb_write_enable = xfer_prev;
      bus.wb_rd = xfer_rd;
      bus.wb_value = xfer_val;
      if (!have_pend && issued < 300 && $urandom_range(0, 3) != 0) begin
        rop = $urandom_range(0, 9);
        pend.op = (rop > 7) ? 3'd0 : 3'(rop);
        pend.rs = 5'($urandom_range(0, 7));
        pend.rt = 5'($urandom_range(0, 7));
        pend.rd = 5'($urandom_range(0, 7));
        pend.imm = $urandom;
        pend.use_imm = ($urandom_range(0, 3) == 0);
        have_pend = 1;
        issued++;
      end
      bus.in_valid = have_pend;
      bus.in_operator = pend.op;
      bus.in_rs = pend.rs;
      bus.in_rt = pend.rt;
      bus.in_rd = pend.rd;
      bus.in_rs_value = rf[pend.rs];
      bus.in_rt_value = rf[pend.rt];
      bus.in_immediate = pend.imm;
      bus.in_use_immediate = pend.use_imm;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_prev) begin
        test_count++; if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, hold_rd, hold_res}) begin
          $display("[TB] FAIL rand_stable: cycle %0d got valid=%b rd=%0d result=%h want 1/%0d/%h",
                   cyc, bus.out_valid, bus.out_rd, bus.out_result, hold_rd, hold_res); fail_count++; end
      end
      if (bus.in_valid && bus.in_ready) begin
        inflight.push_back(pend);
        have_pend = 0;
      end
      xfer_prev = bus.out_valid && bus.out_ready;
      if (xfer_prev) begin
        test_count++;
        if (inflight.size() == 0) begin
          $display("[TB] FAIL rand_spurious: cycle %0d got result=%h rd=%0d want no output", cyc, bus.out_result, bus.out_rd);
          fail_count++;
        end else begin
          done_instr = inflight.pop_front();
          opb = done_instr.use_imm ? done_instr.imm : arch[done_instr.rt];
          exp_val = ref_alu(done_instr.op, arch[done_instr.rs], opb);
          if ({bus.out_rd, bus.out_result} !== {done_instr.rd, exp_val}) begin
            $display("[TB] FAIL rand_result: cycle %0d got rd=%0d result=%h want rd=%0d result=%h",
                     cyc, bus.out_rd, bus.out_result, done_instr.rd, exp_val);
            fail_count++;
          end
          if (done_instr.rd != 5'd0) arch[done_instr.rd] = exp_val;
        end
      end
      xfer_rd = bus.out_rd;
      xfer_val = bus.out_result;
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_rd = bus.out_rd;
      hold_res = bus.out_result;
      @(posedge clock);
      #1;
    end
    test_count++;
    if (!finished) begin
      $display("[TB] FAIL rand_timeout: got %0d still in flight want 0", inflight.size());
      fail_count++;
    end
    set_idle();
    step();
  endtask

  initial begin
    test_count = 0;
    fail_count = 0;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    set_idle();
    test_reset();
    test_dependency();
    test_immediate();
    test_backpressure();
    test_r0();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
